disp_frame_sched: RTL and testbench

//  Display-refresh scheduler for the debug text screen. Every refresh period it walks NPAGE 128-bit debug pages.
//  Per page it drives the page onto the hex->ASCII converter and captures the 256-bit (32-char) string.
//  It streams the 32 chars, MSB char first, to the text-RAM/LCD writer over a valid/ready handshake.

---
 rtl/disp_frame_sched_if.sv | 32 +++
 rtl/disp_frame_sched.sv | 210 +++++++++++++++++++++
 tb/tb_disp_frame_sched.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_frame_sched_if.sv
// ---------------------------------------------------------------------------
// disp_frame_sched_if
//   Character stream from the display-refresh scheduler to the text-RAM/LCD
//   writer. A character moves on every cycle where ch_valid & ch_ready.
//
//   ch_valid  scheduler -> writer   character available
//   ch_ready  writer -> scheduler   writer accepts the character
//   ch_data   scheduler -> writer   ASCII character
//   ch_addr   scheduler -> writer   {row = page index, col 0..31}
// ---------------------------------------------------------------------------
interface disp_frame_sched_if #(
    parameter int PAGE_W = 2
);
    logic              ch_valid;
    logic              ch_ready;
    logic [7:0]        ch_data;
    logic [PAGE_W+4:0] ch_addr;

    modport master (
        output ch_valid,
        output ch_data,
        output ch_addr,
        input  ch_ready
    );

    modport slave (
        input  ch_valid,
        input  ch_data,
        input  ch_addr,
        output ch_ready
    );
endinterface

// File: rtl/disp_frame_sched.sv
// ---------------------------------------------------------------------------
// disp_frame_sched
//   Display-refresh scheduler for the debug text screen. Once per refresh
//   period it walks all 2**PAGE_W 128-bit debug pages; for each page it
//   presents the page to an external hex->ASCII converter, captures the
//   32-character string, and streams the characters (MSB character first)
//   to the display writer over a valid/ready handshake.
//
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   page_data   page p at bits [128p+127:128p]
//   hold        1 = do not start a new frame (a running frame completes)
//   conv_in     registered page driven to the converter
//   conv_str    converter result, combinational from conv_in
//   ch          character stream (master side)
//   busy        scheduler is not idle
//   frame_done  one-cycle pulse when a frame has been fully sent
//   frame_cnt   completed frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module disp_frame_sched #(
    parameter int PAGE_W      = 2,
    parameter int REFRESH_CYC = 50000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [128*(2**PAGE_W)-1:0] page_data,
    input  logic                       hold,
    output logic [127:0]               conv_in,
    input  logic [255:0]               conv_str,
    disp_frame_sched_if.master         ch,
    output logic                       busy,
    output logic                       frame_done,
    output logic [7:0]                 frame_cnt
);

    localparam int                CNT_W     = (REFRESH_CYC > 2) ? $clog2(REFRESH_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_CYC - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = {PAGE_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_CONV  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                tick_s;
    logic                pend_r;
    logic                start_s;
    logic                xfer_s;
    logic                last_col_s;
    logic                last_page_s;
    logic [PAGE_W-1:0]   page_r;
    logic [4:0]          col_r;
    logic [4:0]          col_inc_s;
    logic [255:0]        str_r;
    logic [127:0]        conv_in_r;
    logic                ch_valid_r;
    logic [7:0]          ch_data_r;
    logic [PAGE_W+4:0]   ch_addr_r;
    logic                frame_done_r;
    logic [7:0]          frame_cnt_r;

    // Column c of the string sits at bits [255-8c -: 8]; 255-8c == {~c, 3'b111}.
    function automatic logic [7:0] char_at(input logic [255:0] str, input logic [4:0] col);
        char_at = str[{~col, 3'b111} -: 8];
    endfunction

    assign tick_s      = (cnt_r == CNT_LAST);
    assign start_s     = (state_r == ST_IDLE) && (tick_s || pend_r) && !hold;
    assign xfer_s      = ch_valid_r && ch.ch_ready;
    assign last_col_s  = (col_r == 5'd31);
    assign last_page_s = (page_r == PAGE_LAST);
    assign col_inc_s   = col_r + 5'd1;

    assign conv_in     = conv_in_r;
    assign ch.ch_valid = ch_valid_r;
    assign ch.ch_data  = ch_data_r;
    assign ch.ch_addr  = ch_addr_r;
    assign frame_done  = frame_done_r;
    assign frame_cnt   = frame_cnt_r;
    assign busy        = (state_r != ST_IDLE);

    // Free-running refresh period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // One-deep request for a frame whose tick arrived while a frame was running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= 1'b0;
        end else if (start_s) begin
            pend_r <= 1'b0;
        end else if (tick_s && (state_r != ST_IDLE)) begin
            pend_r <= 1'b1;
        end else begin
            pend_r <= pend_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nx_s = ST_LATCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LATCH: state_nx_s = ST_CONV;
            ST_CONV:  state_nx_s = ST_SEND;
            ST_SEND: begin
                if (xfer_s && last_col_s) begin
                    if (last_page_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_LATCH;
                    end
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_DONE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Page/column walk, converter capture and registered character stream.
    // ch_valid and the first character of a page are loaded in CONV so they
    // appear together with the SEND state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_r       <= '0;
            col_r        <= 5'd0;
            str_r        <= 256'd0;
            conv_in_r    <= 128'd0;
            ch_valid_r   <= 1'b0;
            ch_data_r    <= 8'd0;
            ch_addr_r    <= '0;
            frame_done_r <= 1'b0;
            frame_cnt_r  <= 8'd0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        page_r <= '0;
                        col_r  <= 5'd0;
                    end
                end
                ST_LATCH: begin
                    conv_in_r <= page_data[{page_r, 7'd0} +: 128];
                end
                ST_CONV: begin
                    str_r      <= conv_str;
                    col_r      <= 5'd0;
                    ch_valid_r <= 1'b1;
                    ch_data_r  <= char_at(conv_str, 5'd0);
                    ch_addr_r  <= {page_r, 5'd0};
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        if (!last_col_s) begin
                            col_r     <= col_inc_s;
                            ch_data_r <= char_at(str_r, col_inc_s);
                            ch_addr_r <= {page_r, col_inc_s};
                        end else begin
                            ch_valid_r <= 1'b0;
                            if (!last_page_s) begin
                                page_r <= page_r + PAGE_W'(1);
                            end else begin
                                frame_done_r <= 1'b1;
                                frame_cnt_r  <= frame_cnt_r + 8'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    frame_done_r <= 1'b0;
                end
                default: begin
                    ch_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_disp_frame_sched
//   Directed bench for disp_frame_sched with PAGE_W=1, REFRESH_CYC=16.
//   The bench supplies a hex->ASCII converter and checks the character
//   stream, handshake, frame scheduling, hold, reset and frame counter.
// ---------------------------------------------------------------------------
module tb_disp_frame_sched;

    localparam int PAGE_W      = 1;
    localparam int REFRESH_CYC = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         hold  = 1'b0;
    logic [255:0] page_data;
    logic [127:0] conv_in;
    logic [255:0] conv_str;
    logic         busy;
    logic         frame_done;
    logic [7:0]   frame_cnt;
    logic [127:0] pages [2];

    int n_tests = 0;
    int n_fail  = 0;

    disp_frame_sched_if #(.PAGE_W(PAGE_W)) ch_if ();

    disp_frame_sched #(
        .PAGE_W      (PAGE_W),
        .REFRESH_CYC (REFRESH_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .page_data  (page_data),
        .hold       (hold),
        .conv_in    (conv_in),
        .conv_str   (conv_str),
        .ch         (ch_if),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] nib_asc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    // Converter model: nibble i of the page becomes character i of the string.
    function automatic logic [255:0] conv_model(input logic [127:0] v);
        logic [255:0] s;
        s = 256'd0;
        for (int i = 0; i < 32; i++) s[8*i +: 8] = nib_asc(v[4*i +: 4]);
        return s;
    endfunction

    // Expected character number idx of a frame (page idx/32, column idx%32).
    function automatic logic [7:0] exp_char(input int idx);
        logic [127:0] w;
        int col;
        w   = pages[idx / 32];
        col = idx % 32;
        return nib_asc(w[4*(31-col) +: 4]);
    endfunction

    assign conv_str  = conv_model(conv_in);
    assign page_data = {pages[1], pages[0]};

    // Collects one frame from the current negedge until frame_done; optional
    // stall of stall_len cycles on character stall_idx and hold raised after
    // hold_idx characters. Ends one cycle after the frame_done pulse.
    task automatic run_frame(input int stall_idx, input int stall_len, input int hold_idx,
                             input logic [7:0] exp_cnt);
        int idx = 0;
        int cyc = 0;
        int dones = 0;
        int stall_left;
        bit in_stall = 1'b0;
        stall_left = stall_len;
        while (dones == 0 && cyc < 400) begin
            if (frame_done) begin
                dones++;
                n_tests++;
                if (idx !== 64 || frame_cnt !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL frame_end: chars=%0d cnt=%0d, want chars=64 cnt=%0d", idx, frame_cnt, exp_cnt);
                end
            end else if (ch_if.ch_valid) begin
                n_tests++;
                if (idx > 63) begin
                    n_fail++;
                    $display("FAIL extra_char: got char #%0d addr=%h, want no more than 64", idx, ch_if.ch_addr);
                end else if (ch_if.ch_data !== exp_char(idx) || ch_if.ch_addr !== idx[5:0]) begin
                    n_fail++;
                    $display("FAIL char_%0d: got data=%h addr=%h, want data=%h addr=%h",
                             idx, ch_if.ch_data, ch_if.ch_addr, exp_char(idx), idx[5:0]);
                end
                if (idx == stall_idx && stall_left > 0) begin
                    ch_if.ch_ready = 1'b0;
                    stall_left--;
                    in_stall = 1'b1;
                end else begin
                    ch_if.ch_ready = 1'b1;
                    in_stall = 1'b0;
                    idx++;
                    if (idx == hold_idx) hold = 1'b1;
                end
            end else begin
                if (in_stall) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL valid_drop: got ch_valid=0 during stall at char %0d, want 1", idx);
                end
                in_stall = 1'b0;
                ch_if.ch_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (dones == 0) begin
            n_fail++;
            $display("FAIL frame_timeout: got no frame_done in %0d cycles (%0d chars), want one", cyc, idx);
        end else if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got frame_done=%b one cycle later, want 0", frame_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ch_if.ch_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ch_if.ch_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || ch_if.ch_data !== 8'd0 ||
            ch_if.ch_addr !== 6'd0 || conv_in !== 128'd0 || frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b busy=%b done=%b data=%h addr=%h cnt=%0d, want all 0",
                     ch_if.ch_valid, busy, frame_done, ch_if.ch_data, ch_if.ch_addr, frame_cnt);
        end
        rst_n = 1'b1;
        // Tick lands in cycle 15 after release; first char 3 cycles later.
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 15) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tick_early: got busy=%b at cycle 15, want 0", busy);
                end
            end
            if (k == 16) begin
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tick_start: got busy=%b at cycle 16, want 1", busy);
                end
            end
            if (k == 17) begin
                n_tests++;
                if (ch_if.ch_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL latency_early: got ch_valid=%b at tick+2, want 0", ch_if.ch_valid);
                end
            end
            if (k == 18) begin
                n_tests++;
                if (ch_if.ch_valid !== 1'b1 || ch_if.ch_addr !== 6'd0 || ch_if.ch_data !== 8'h30) begin
                    n_fail++;
                    $display("FAIL latency_first: got valid=%b addr=%h data=%h at tick+3, want 1 00 30",
                             ch_if.ch_valid, ch_if.ch_addr, ch_if.ch_data);
                end
            end
        end
    endtask

    task automatic test_first_frame();
        run_frame(-1, 0, -1, 8'd1);
    endtask

    // Ticks during frame 1 leave one pending frame which starts right after DONE.
    task automatic test_overlap();
        n_tests++;
        if (busy !== 1'b0 || frame_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL overlap_idle: got busy=%b cnt=%0d after DONE, want 0 1", busy, frame_cnt);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL overlap_start: got busy=%b, want 1 (pending frame)", busy);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (ch_if.ch_valid !== 1'b1 || ch_if.ch_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL overlap_first: got valid=%b addr=%h, want 1 00", ch_if.ch_valid, ch_if.ch_addr);
        end
    endtask

    // Stall 5 cycles on col 3; hold raised at col 10 must not cut the frame.
    task automatic test_backpressure();
        run_frame(3, 5, 10, 8'd2);
    endtask

    task automatic test_hold_idle();
        for (int k = 0; k < 3 * REFRESH_CYC + 4; k++) begin
            n_tests++;
            if (busy !== 1'b0 || ch_if.ch_valid !== 1'b0 || frame_done !== 1'b0 || frame_cnt !== 8'd2) begin
                n_fail++;
                $display("FAIL hold_idle: got busy=%b valid=%b done=%b cnt=%0d, want 0 0 0 2",
                         busy, ch_if.ch_valid, frame_done, frame_cnt);
            end
            @(negedge clk);
        end
        hold = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got busy=%b, want 1 (pending kept)", busy);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (ch_if.ch_valid !== 1'b1 || ch_if.ch_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL hold_first: got valid=%b addr=%h, want 1 00", ch_if.ch_valid, ch_if.ch_addr);
        end
        run_frame(-1, 0, 10, 8'd3);
    endtask

    task automatic test_reset_mid_frame();
        int cyc = 0;
        hold = 1'b0;
        ch_if.ch_ready = 1'b1;
        while (!(ch_if.ch_valid === 1'b1 && ch_if.ch_addr === 6'd39) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc >= 200) begin
            n_fail++;
            $display("FAIL mid_wait: got no addr 27 within %0d cycles, want it", cyc);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ch_if.ch_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0 || ch_if.ch_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b busy=%b cnt=%0d addr=%h, want 0 0 0 00",
                     ch_if.ch_valid, busy, frame_cnt, ch_if.ch_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 17) begin
                n_tests++;
                if (ch_if.ch_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_latency: got ch_valid=%b at tick+2, want 0", ch_if.ch_valid);
                end
            end
            if (k == 18) begin
                n_tests++;
                if (ch_if.ch_valid !== 1'b1 || ch_if.ch_addr !== 6'd0 || frame_cnt !== 8'd0) begin
                    n_fail++;
                    $display("FAIL rst_restart: got valid=%b addr=%h cnt=%0d, want 1 00 0",
                             ch_if.ch_valid, ch_if.ch_addr, frame_cnt);
                end
            end
        end
        run_frame(-1, 0, -1, 8'd1);
    endtask

    // Back-to-back pending frames until the counter wraps 255 -> 0.
    task automatic test_wrap();
        int dones = 0;
        int cyc = 0;
        ch_if.ch_ready = 1'b1;
        while (dones < 255 && cyc < 256 * 100) begin
            @(negedge clk);
            cyc++;
            if (frame_done === 1'b1) begin
                dones++;
                if (dones == 254) begin
                    n_tests++;
                    if (frame_cnt !== 8'd255) begin
                        n_fail++;
                        $display("FAIL wrap_255: got cnt=%0d, want 255", frame_cnt);
                    end
                end
                if (dones == 255) begin
                    n_tests++;
                    if (frame_cnt !== 8'd0) begin
                        n_fail++;
                        $display("FAIL wrap_0: got cnt=%0d, want 0", frame_cnt);
                    end
                end
            end
        end
        n_tests++;
        if (dones < 255) begin
            n_fail++;
            $display("FAIL wrap_timeout: got %0d frames in %0d cycles, want 255", dones, cyc);
        end
    endtask

    initial begin
        pages[0] = 128'h0123456789ABCDEF_0011223344556677;
        pages[1] = 128'hFEDCBA9876543210_A5A55A5AC3C33C3C;
        test_reset();
        test_first_frame();
        test_overlap();
        test_backpressure();
        test_hold_idle();
        test_reset_mid_frame();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
